// File: rtl/adc_pkg.sv
// Shared definitions for the AD400x capture front end: FSM encoding, supported
// frame widths, sign extension and configuration legality.
package adc_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } adc_state_e;

   localparam int ADC_W16          = 16;
   localparam int ADC_W18          = 18;
   localparam int ADC_W20          = 20;
   localparam int ADC_MAX_CHANNELS = 48;
   localparam int ADC_EXT_MAX      = 64;

   // Sign-extend the low `width` bits of raw (the widest supported frame) to 64 bits.
   function automatic logic [ADC_EXT_MAX-1:0] adc_sign_ext(input logic [ADC_W20-1:0] raw,
                                                          input int               width);
      logic [ADC_EXT_MAX-1:0] keep;
      logic [ADC_EXT_MAX-1:0] res;
      logic [4:0]             msb;
      keep = (64'd1 << width) - 64'd1;
      msb  = 5'(width - 1);
      res  = {44'd0, raw} & keep;
      if (raw[msb]) begin
         res = res | ~keep;
      end else begin
         res = res;
      end
      return res;
   endfunction

   function automatic bit adc_cfg_ok(input int channels, input int data_w, input int out_w);
      return ((channels % 2) == 0) && (channels >= 2) && (channels <= ADC_MAX_CHANNELS) &&
             ((data_w == ADC_W16) || (data_w == ADC_W18) || (data_w == ADC_W20)) &&
             (out_w >= data_w) && (out_w <= ADC_EXT_MAX);
   endfunction

endpackage

// File: rtl/adc_capture_block_lane.sv
// One SDO lane: differential receive, single input register and an MSB-first
// shift register advanced by the shared control FSM.
module adc_ad400x_lane
   import adc_pkg::*;
#(
   parameter int ADC_DATA_WIDTH = ADC_W18
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_sdo_p,
   input  logic                      i_sdo_n,
   input  logic                      i_shift_en,
   output logic [ADC_DATA_WIDTH-1:0] o_data
);

   logic                      w_sdo;
   logic                      r_sdo;
   logic [ADC_DATA_WIDTH-1:0] r_sr;

   // Differential receiver: a collapsed pair (p==n) reads as 0.
   assign w_sdo = i_sdo_p & ~i_sdo_n;

   // Input register and frame shift register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sdo <= 1'b0;
         r_sr  <= '0;
      end else begin
         r_sdo <= w_sdo;
         if (i_shift_en) begin
            r_sr <= {r_sr[ADC_DATA_WIDTH-2:0], r_sdo};
         end else begin
            r_sr <= r_sr;
         end
      end
   end

   assign o_data = r_sr;

endmodule

// File: rtl/adc_capture_block.sv
// Multi-channel AD400x capture: shared read-window FSM, frame-length check,
// sign-extended output bank with valid/error strobes and a good-frame counter.
module adc_capture_block
   import adc_pkg::*;
#(
   parameter int ADC_CHANNELS   = 8,
   parameter int ADC_MODULES    = ADC_CHANNELS / 2,
   parameter int ADC_DATA_WIDTH = ADC_W18,
   parameter int OUT_WIDTH      = 32,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                              adc_read_clk,
   input  logic                              rstn,
   input  logic [ADC_MODULES-1:0]            adc_sdo_cha_p,
   input  logic [ADC_MODULES-1:0]            adc_sdo_cha_n,
   input  logic [ADC_MODULES-1:0]            adc_sdo_chb_p,
   input  logic [ADC_MODULES-1:0]            adc_sdo_chb_n,
   input  logic                              reader_en_sync,
   output logic [OUT_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
   output logic                              data_valid,
   output logic                              frame_err,
   output logic [CNT_WIDTH-1:0]              sample_cnt
);

   localparam int              BC_W    = $clog2(ADC_DATA_WIDTH + 2);
   localparam logic [BC_W-1:0] BC_FULL = BC_W'(ADC_DATA_WIDTH);
   localparam logic [BC_W-1:0] BC_SAT  = BC_W'(ADC_DATA_WIDTH + 1);

   if (!adc_cfg_ok(ADC_CHANNELS, ADC_DATA_WIDTH, OUT_WIDTH) || (ADC_MODULES * 2 != ADC_CHANNELS)) begin : g_cfg_err
      $error("adc_capture_block: unsupported channel count or width configuration");
   end

   adc_state_e                      r_state;
   adc_state_e                      w_state_nxt;
   logic [BC_W-1:0]                 r_bit_cnt;
   logic [BC_W-1:0]                 w_bit_cnt_nxt;
   logic                            r_en;
   logic                            w_shift_en;
   logic                            w_frame_good;
   logic                            w_frame_bad;
   logic [ADC_DATA_WIDTH-1:0]       w_lane_data [ADC_CHANNELS];
   logic [OUT_WIDTH*ADC_CHANNELS-1:0] w_ext_arr;
   logic [OUT_WIDTH*ADC_CHANNELS-1:0] r_data_arr;
   logic                            r_valid;
   logic                            r_err;
   logic [CNT_WIDTH-1:0]            r_cnt;

   for (genvar k = 0; k < ADC_MODULES; k++) begin : g_mod
      adc_ad400x_lane #(.ADC_DATA_WIDTH(ADC_DATA_WIDTH)) u_lane_a (
         .i_clk      (adc_read_clk),
         .i_rst_n    (rstn),
         .i_sdo_p    (adc_sdo_cha_p[k]),
         .i_sdo_n    (adc_sdo_cha_n[k]),
         .i_shift_en (w_shift_en),
         .o_data     (w_lane_data[2*k])
      );
      adc_ad400x_lane #(.ADC_DATA_WIDTH(ADC_DATA_WIDTH)) u_lane_b (
         .i_clk      (adc_read_clk),
         .i_rst_n    (rstn),
         .i_sdo_p    (adc_sdo_chb_p[k]),
         .i_sdo_n    (adc_sdo_chb_n[k]),
         .i_shift_en (w_shift_en),
         .o_data     (w_lane_data[2*k+1])
      );
   end

   // Window register and FSM state/bit counter.
   always_ff @(posedge adc_read_clk or negedge rstn) begin
      if (!rstn) begin
         r_en      <= 1'b0;
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
      end else begin
         r_en      <= reader_en_sync;
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
      end
   end

   // Next state, shift enable and frame verdict; the counter saturates to flag long frames.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_en    = 1'b0;
      w_frame_good  = 1'b0;
      w_frame_bad   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_en) begin
               w_state_nxt   = ST_SHIFT;
               w_bit_cnt_nxt = BC_W'(1);
               w_shift_en    = 1'b1;
            end else begin
               w_state_nxt   = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (r_en) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt != BC_SAT) begin
                  w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt;
               end
            end else begin
               w_state_nxt = ST_IDLE;
               if (r_bit_cnt == BC_FULL) begin
                  w_frame_good = 1'b1;
               end else begin
                  w_frame_bad  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Sign-extend every lane into its channel slot.
   always_comb begin
      w_ext_arr = '0;
      for (int c = 0; c < ADC_CHANNELS; c++) begin
         w_ext_arr[OUT_WIDTH*c +: OUT_WIDTH] =
            OUT_WIDTH'(adc_sign_ext(ADC_W20'(w_lane_data[c]), ADC_DATA_WIDTH));
      end
   end

   // Output bank, strobes and good-frame counter.
   always_ff @(posedge adc_read_clk or negedge rstn) begin
      if (!rstn) begin
         r_data_arr <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_valid <= w_frame_good;
         r_err   <= w_frame_bad;
         if (w_frame_good) begin
            r_data_arr <= w_ext_arr;
            r_cnt      <= r_cnt + CNT_WIDTH'(1);
         end else begin
            r_data_arr <= r_data_arr;
            r_cnt      <= r_cnt;
         end
      end
   end

   assign adc_data_arr = r_data_arr;
   assign data_valid   = r_valid;
   assign frame_err    = r_err;
   assign sample_cnt   = r_cnt;

endmodule

// File: tb/tb_adc_capture_block.sv
// Directed bench for adc_capture_block: two configurations checked every cycle
// against a frame-level model, plus hand-computed spot values.
`timescale 1ns/1ps
module tb_adc_capture_block;

   localparam int W_A = 18, CH_A = 4, M_A = 2, OW_A = 32;
   localparam int W_B = 16, CH_B = 48, M_B = 24, OW_B = 16, CW_B = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;

   logic                 en_a = 1'b0;
   logic [M_A-1:0]       cha_a = '0, chb_a = '0;
   logic [OW_A*CH_A-1:0] arr_a;
   logic                 dv_a, fe_a;
   logic [31:0]          cnt_a;

   logic                 en_b = 1'b0;
   logic [M_B-1:0]       cha_b = '0, chb_b = '0;
   logic [OW_B*CH_B-1:0] arr_b;
   logic                 dv_b, fe_b;
   logic [CW_B-1:0]      cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int               due;
      bit               good;
      logic [CH_B*20-1:0] raw;
   } ev_t;

   ev_t             qa[$];
   ev_t             qb[$];
   logic [OW_A-1:0] ea[CH_A];
   logic [31:0]     ecnt_a = '0;
   logic [OW_B-1:0] eb[CH_B];
   logic [CW_B-1:0] ecnt_b = '0;

   adc_capture_block #(.ADC_CHANNELS(CH_A), .ADC_DATA_WIDTH(W_A), .OUT_WIDTH(OW_A), .CNT_WIDTH(32)) dut_a (
      .adc_read_clk(clk), .rstn(rstn),
      .adc_sdo_cha_p(cha_a), .adc_sdo_cha_n(~cha_a),
      .adc_sdo_chb_p(chb_a), .adc_sdo_chb_n(~chb_a),
      .reader_en_sync(en_a), .adc_data_arr(arr_a),
      .data_valid(dv_a), .frame_err(fe_a), .sample_cnt(cnt_a));

   adc_capture_block #(.ADC_CHANNELS(CH_B), .ADC_DATA_WIDTH(W_B), .OUT_WIDTH(OW_B), .CNT_WIDTH(CW_B)) dut_b (
      .adc_read_clk(clk), .rstn(rstn),
      .adc_sdo_cha_p(cha_b), .adc_sdo_cha_n(~cha_b),
      .adc_sdo_chb_p(chb_b), .adc_sdo_chb_n(~chb_b),
      .reader_en_sync(en_b), .adc_data_arr(arr_b),
      .data_valid(dv_b), .frame_err(fe_b), .sample_cnt(cnt_b));

   always #6 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", nm, idx, cyc, act, exp);
      end
   endtask

   // Two's-complement value of a w-bit raw sample, as a 64-bit pattern.
   function automatic logic [63:0] sext(input int v, input int w);
      longint s;
      if (v >= (1 << (w - 1))) s = longint'(v) - (longint'(1) << w);
      else                     s = longint'(v);
      return 64'(s);
   endfunction

   // Model: a frame published by the driver takes effect at its due cycle.
   always @(negedge clk) begin
      logic exp_dv_a, exp_fe_a, exp_dv_b, exp_fe_b;
      exp_dv_a = 1'b0; exp_fe_a = 1'b0; exp_dv_b = 1'b0; exp_fe_b = 1'b0;
      if (!rstn) begin
         qa.delete(); qb.delete();
         for (int c = 0; c < CH_A; c++) ea[c] = '0;
         for (int c = 0; c < CH_B; c++) eb[c] = '0;
         ecnt_a = '0; ecnt_b = '0;
      end else begin
         if (qa.size() > 0 && qa[0].due == cyc) begin
            if (qa[0].good) begin
               exp_dv_a = 1'b1;
               for (int c = 0; c < CH_A; c++) ea[c] = OW_A'(sext(int'(qa[0].raw[c*20 +: 20]), W_A));
               ecnt_a = ecnt_a + 32'd1;
            end else begin
               exp_fe_a = 1'b1;
            end
            void'(qa.pop_front());
         end
         if (qb.size() > 0 && qb[0].due == cyc) begin
            if (qb[0].good) begin
               exp_dv_b = 1'b1;
               for (int c = 0; c < CH_B; c++) eb[c] = OW_B'(sext(int'(qb[0].raw[c*20 +: 20]), W_B));
               ecnt_b = ecnt_b + 4'd1;
            end else begin
               exp_fe_b = 1'b1;
            end
            void'(qb.pop_front());
         end
      end
      chk("dv_a", 0, 64'(dv_a), 64'(exp_dv_a));
      chk("fe_a", 0, 64'(fe_a), 64'(exp_fe_a));
      chk("cnt_a", 0, 64'(cnt_a), 64'(ecnt_a));
      for (int c = 0; c < CH_A; c++) chk("arr_a", c, 64'(arr_a[OW_A*c +: OW_A]), 64'(ea[c]));
      chk("dv_b", 0, 64'(dv_b), 64'(exp_dv_b));
      chk("fe_b", 0, 64'(fe_b), 64'(exp_fe_b));
      chk("cnt_b", 0, 64'(cnt_b), 64'(ecnt_b));
      for (int c = 0; c < CH_B; c++) chk("arr_b", c, 64'(arr_b[OW_B*c +: OW_B]), 64'(eb[c]));
   end

   task automatic idle(input int n);
      en_a = 1'b0; en_b = 1'b0;
      cha_a = '0; chb_a = '0; cha_b = '0; chb_b = '0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one window of len cycles, MSB first, zero-padded past W_A bits.
   task automatic drive_a(input int len, input logic [CH_A*18-1:0] vals);
      ev_t e;
      e.due = cyc + len + 2;
      e.good = (len == W_A);
      e.raw = '0;
      for (int c = 0; c < CH_A; c++) e.raw[c*20 +: 20] = 20'(vals[c*18 +: 18]);
      qa.push_back(e);
      for (int i = 0; i < len; i++) begin
         en_a = 1'b1;
         for (int k = 0; k < M_A; k++) begin
            if (i < W_A) begin
               cha_a[k] = vals[(2*k)*18 + (W_A - 1 - i)];
               chb_a[k] = vals[(2*k+1)*18 + (W_A - 1 - i)];
            end else begin
               cha_a[k] = 1'b0;
               chb_a[k] = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      en_a = 1'b0; cha_a = '0; chb_a = '0;
   endtask

   task automatic drive_b(input logic [15:0] v);
      ev_t e;
      e.due = cyc + W_B + 2;
      e.good = 1'b1;
      e.raw = '0;
      for (int c = 0; c < CH_B; c++) e.raw[c*20 +: 20] = 20'(v);
      qb.push_back(e);
      for (int i = 0; i < W_B; i++) begin
         en_b = 1'b1;
         cha_b = {M_B{v[W_B-1-i]}};
         chb_b = {M_B{v[W_B-1-i]}};
         @(posedge clk); #1;
      end
      en_b = 1'b0; cha_b = '0; chb_b = '0;
   endtask

   // From just after drive_x returns, land on the strobe cycle's sampling edge.
   task automatic to_strobe();
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [CH_A*18-1:0] v1, vr;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arr_a", 0, 64'(arr_a[31:0]), 64'h0);
      chk("rst_cnt_a", 0, 64'(cnt_a), 64'h0);
      rstn = 1'b1;
      idle(2);

      v1 = {18'h15555, 18'h00000, 18'h1FFFF, 18'h20001};
      drive_a(W_A, v1);
      to_strobe();
      chk("lit_dv", 0, 64'(dv_a), 64'h1);
      chk("lit_ch", 0, 64'(arr_a[31:0]),   64'hFFFE0001);
      chk("lit_ch", 1, 64'(arr_a[63:32]),  64'h0001FFFF);
      chk("lit_ch", 2, 64'(arr_a[95:64]),  64'h00000000);
      chk("lit_ch", 3, 64'(arr_a[127:96]), 64'h00015555);
      chk("lit_cnt", 0, 64'(cnt_a), 64'd1);
      @(posedge clk); #1;
      chk("lit_dv_pulse", 0, 64'(dv_a), 64'h0);

      vr = {18'h3FFFF, 18'h2AAAA, 18'h00001, 18'h1C3C3};
      drive_a(W_A - 1, vr);
      to_strobe();
      chk("lit_short_fe", 0, 64'(fe_a), 64'h1);
      chk("lit_short_dv", 0, 64'(dv_a), 64'h0);
      @(posedge clk); #1;
      drive_a(W_A + 1, vr);
      to_strobe();
      chk("lit_long_fe", 0, 64'(fe_a), 64'h1);
      chk("lit_long_cnt", 0, 64'(cnt_a), 64'd1);
      chk("lit_long_ch0", 0, 64'(arr_a[31:0]), 64'hFFFE0001);
      @(posedge clk); #1;

      for (int f = 0; f < 100; f++) begin
         for (int c = 0; c < CH_A; c++) vr[c*18 +: 18] = 18'((f + 1) * 2621 + c * 49153);
         drive_a(W_A, vr);
         idle(1);
      end
      idle(4);
      chk("lit_cnt_101", 0, 64'(cnt_a), 64'd101);

      for (int i = 0; i < 9; i++) begin
         en_a = 1'b1; cha_a = '1; chb_a = '0;
         @(posedge clk); #1;
      end
      rstn = 1'b0; en_a = 1'b0; cha_a = '0;
      @(negedge clk);
      chk("mid_rst_cnt", 0, 64'(cnt_a), 64'h0);
      chk("mid_rst_ch0", 0, 64'(arr_a[31:0]), 64'h0);
      chk("mid_rst_dv", 0, 64'(dv_a), 64'h0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      idle(2);
      drive_a(W_A, v1);
      to_strobe();
      chk("post_rst_cnt", 0, 64'(cnt_a), 64'd1);
      chk("post_rst_ch3", 0, 64'(arr_a[127:96]), 64'h00015555);
      @(posedge clk); #1;

      for (int f = 1; f <= 17; f++) begin
         drive_b(16'h8000);
         to_strobe();
         chk("b_cnt", f, 64'(cnt_b), 64'(f % 16));
         @(posedge clk); #1;
      end
      chk("b_ch0", 0, 64'(arr_b[15:0]), 64'h8000);
      chk("b_ch47", 47, 64'(arr_b[OW_B*47 +: OW_B]), 64'h8000);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
